// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: PC/instruction-memory side plus the decode-facing head of the queue.
// slave = fetch_buffer, master = surrounding pipeline / memory.
interface fetch_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] PCResult;
    logic              PCAdvance;
    logic              IMemRead;
    logic [ADDR_W-1:0] IMemAddr;
    logic [DATA_W-1:0] IMemData;
    logic              Flush;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutInstr;
    logic [ADDR_W-1:0] OutPC;
    logic [CNT_W-1:0]  Count;

    modport slave (
        input  PCResult, IMemData, Flush, OutReady,
        output PCAdvance, IMemRead, IMemAddr, OutValid, OutInstr, OutPC, Count
    );

    modport master (
        output PCResult, IMemData, Flush, OutReady,
        input  PCAdvance, IMemRead, IMemAddr, OutValid, OutInstr, OutPC, Count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: issues 1-cycle-latency imem reads and queues {PC, instr} for decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           Clk,
    input logic           Reset,
    fetch_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic [CNT_W:0] occupancy;
    logic           issue;
    logic           fifo_nonempty;
    logic           bypass;
    logic           push;
    logic           pop_fifo;

    always_comb begin
        // Credit counts the in-flight read but ignores a same-cycle pop, so no overflow.
        occupancy     = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue         = Reset & ~bus.Flush & (occupancy < DEPTH_OCC);
        fifo_nonempty = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        bypass        = ~fifo_nonempty & inflight_q & ~bus.Flush;
`else
        bypass        = 1'b0;
`endif
        pop_fifo      = fifo_nonempty & bus.OutReady & ~bus.Flush;
        push          = inflight_q & ~bus.Flush & ~(bypass & bus.OutReady);
    end

    assign bus.IMemRead  = issue;
    assign bus.PCAdvance = issue;
    assign bus.IMemAddr  = bus.PCResult;
    assign bus.OutValid  = fifo_nonempty | bypass;
    assign bus.OutInstr  = bypass ? bus.IMemData : instr_mem_q[rd_ptr_q];
    assign bus.OutPC     = bypass ? pend_pc_q    : pc_mem_q[rd_ptr_q];
    assign bus.Count     = count_q;

    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = 1'b0;
        pend_pc_d  = pend_pc_q;
        if (bus.Flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d    = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
            rd_ptr_d   = rd_ptr_q + PTR_W'(pop_fifo);
            wr_ptr_d   = wr_ptr_q + PTR_W'(push);
            inflight_d = issue;
            if (issue) begin
                pend_pc_d = bus.PCResult;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // Entry storage carries no reset; Count gates whether any of it is visible.
    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= pend_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.IMemData;
        end
    end
endmodule
